vec_fill_seq: RTL and testbench
===============================

VEC_FILL_SEQ -- requirements
Module: vec_fill_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 6, meaning number of bits in the target vector (WIDTH >= 1).
REQ-002 SHALL have parameter LSB, default 0, meaning the low index of the target vector; vector declared [LSB+WIDTH-1:LSB].
REQ-003 SHALL have localparam IW = max(1, $clog2(LSB+WIDTH)), meaning the index width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port start, input, 1, a fill request, sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1, which cancels an in-progress fill.
REQ-008 SHALL have port din, input, 1, the serial data bit written at the current index.
REQ-009 SHALL have port out, output, [LSB+WIDTH-1:LSB], the target vector register.
REQ-010 SHALL have port idx, output, IW, the index written in the current FILL cycle.
REQ-011 SHALL have port busy, output, 1, high while state is FILL.
REQ-012 SHALL have port done, output, 1, a one-cycle completion pulse.

Function
REQ-013 SHALL implement an FSM with states IDLE, FILL and DONE, decoded with a case statement.
REQ-014 SHALL derive all bounds from array queries on out ($left, $right, $high, $low, $bits), with no literal widths.
REQ-015 In IDLE, with start=1 and abort=0, SHALL go to FILL next cycle with idx=$left(out); otherwise stay IDLE.
REQ-016 In FILL, each cycle SHALL write out[idx] <= din, leaving all other bits unchanged.
REQ-017 In FILL with idx != $right(out), SHALL decrement idx by 1.
REQ-018 In FILL with idx == $right(out), SHALL go to DONE after writing.
REQ-019 A complete fill SHALL take exactly $bits(out) FILL cycles; done SHALL be high the following cycle.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-021 start in DONE SHALL be ignored; a new fill needs start in IDLE, so the minimum start-to-start spacing is WIDTH+2 cycles.
REQ-022 start while in FILL SHALL be ignored, with no restart and no queuing.
REQ-023 abort=1 in FILL SHALL return to IDLE next cycle without writing that cycle, with out retaining partial contents and done staying 0.
REQ-024 When start and abort are both 1 in IDLE, abort SHALL win: stay IDLE.
REQ-025 abort in IDLE or DONE SHALL have no effect.
REQ-026 With WIDTH=1, the first FILL cycle SHALL also be the last: exactly 1 write, then DONE.
REQ-027 Decrement SHALL never wrap below $low(out); in FILL, idx SHALL stay within [$low, $high].
REQ-028 In IDLE and DONE, idx SHALL hold $left(out).
REQ-029 Outside FILL, out SHALL hold its value; only FILL writes it.
REQ-030 busy SHALL be 1 if and only if state == FILL; done SHALL be 1 if and only if state == DONE.

Reset
REQ-031 rst_n=0 at a posedge SHALL force state=IDLE, out='0, idx=$left(out), busy=0 and done=0, and SHALL take priority over start and abort.
REQ-032 Reset asserted mid-FILL SHALL discard progress: out='0 and no done pulse.
REQ-033 Outputs SHALL be undefined-free after the first reset edge; no initial-block dependence.

Verification
REQ-034 Basic fill: with WIDTH=6, LSB=0, start pulse, then din=1,0,1,1,0,1 over 6 cycles -> out=6'b101101, busy high 6 cycles, done pulse on cycle 7, idx sequence 5,4,3,2,1,0.
REQ-035 Offset range: with WIDTH=4, LSB=3, din all 1 -> out[6:3]=4'hF, idx sequence 6,5,4,3, done once.
REQ-036 Abort: with WIDTH=6, din=1, abort on the 3rd FILL cycle -> out=6'b110000, state IDLE, done never asserted.
REQ-037 Collisions: start held high continuously -> fills back-to-back with WIDTH+2 cycle period; start+abort in IDLE -> stays IDLE.
REQ-038 Reset mid-fill: rst_n=0 on the 4th FILL cycle -> next cycle out=0, idx=5, busy=0, done=0.
REQ-039 Degenerate: with WIDTH=1, LSB=0, start then din=1 -> out=1'b1 after 1 FILL cycle, done the next cycle.

Source files
------------

// File: rtl/vec_fill_seq.sv
// Serial-to-parallel fill sequencer: writes din into out from $left down to $right,
// one bit per FILL cycle, then pulses done for a single cycle.
module vec_fill_seq #(
  parameter int WIDTH = 6,
  parameter int LSB   = 0,
  localparam int IW   = ($clog2(LSB + WIDTH) < 1) ? 1 : $clog2(LSB + WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     din,
  output logic [LSB+WIDTH-1:LSB]   out,
  output logic [IW-1:0]            idx,
  output logic                     busy,
  output logic                     done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IW-1:0] IDX_FIRST = IW'($left(out));
  localparam logic [IW-1:0] IDX_LAST  = IW'($right(out));

  logic [1:0] state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      out   <= '0;
      idx   <= IDX_FIRST;
    end else begin
      case (state)
        S_IDLE: begin
          idx <= IDX_FIRST;
          if (start && !abort) state <= S_FILL;
        end
        S_FILL: begin
          if (abort) begin
            // Abort suppresses this cycle's write; partial contents are kept.
            state <= S_IDLE;
            idx   <= IDX_FIRST;
          end else begin
            out[idx] <= din;
            if (idx == IDX_LAST) begin
              state <= S_DONE;
              idx   <= IDX_FIRST;
            end else begin
              idx <= idx - IW'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          idx   <= IDX_FIRST;
        end
        default: begin
          state <= S_IDLE;
          idx   <= IDX_FIRST;
        end
      endcase
    end
  end

  always_comb begin
    busy = (state == S_FILL);
    done = (state == S_DONE);
  end

endmodule

// File: tb/tb_vec_fill_seq.sv
// Drives three vec_fill_seq configurations from shared stimulus and compares each
// against a counter-based reference of the fill rules.
module tb_vec_fill_seq;

  logic clk = 1'b0;
  logic rst_n, start, abort, din;

  logic [5:0] out0; logic [2:0] idx0; logic busy0, done0;
  logic [6:3] out1; logic [2:0] idx1; logic busy1, done1;
  logic [0:0] out2; logic [0:0] idx2; logic busy2, done2;

  vec_fill_seq #(.WIDTH(6), .LSB(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .din(din),
    .out(out0), .idx(idx0), .busy(busy0), .done(done0));
  vec_fill_seq #(.WIDTH(4), .LSB(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .din(din),
    .out(out1), .idx(idx1), .busy(busy1), .done(done1));
  vec_fill_seq #(.WIDTH(1), .LSB(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .din(din),
    .out(out2), .idx(idx2), .busy(busy2), .done(done2));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference: mode 0=idle 1=filling 2=done; cnt = bits written this fill.
  int          w   [3] = '{6, 4, 1};
  int          l   [3] = '{0, 3, 0};
  int          mode[3];
  int          cnt [3];
  logic [31:0] vec [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        mode[k] = 0; cnt[k] = 0; vec[k] = '0;
      end else if (mode[k] == 0) begin
        if (start && !abort) begin mode[k] = 1; cnt[k] = 0; end
      end else if (mode[k] == 1) begin
        if (abort) mode[k] = 0;
        else begin
          vec[k][l[k] + w[k] - 1 - cnt[k]] = din;
          cnt[k]++;
          if (cnt[k] == w[k]) mode[k] = 2;
        end
      end else begin
        mode[k] = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] go[3], gi[3], gb[3], gd[3];
    go[0] = 32'(out0);      gi[0] = 32'(idx0); gb[0] = 32'(busy0); gd[0] = 32'(done0);
    go[1] = 32'(out1) << 3; gi[1] = 32'(idx1); gb[1] = 32'(busy1); gd[1] = 32'(done1);
    go[2] = 32'(out2);      gi[2] = 32'(idx2); gb[2] = 32'(busy2); gd[2] = 32'(done2);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("u%0d.out", k), go[k], vec[k]);
      check($sformatf("u%0d.idx", k), gi[k],
            32'((mode[k] == 1) ? (l[k] + w[k] - 1 - cnt[k]) : (l[k] + w[k] - 1)));
      check($sformatf("u%0d.busy", k), gb[k], 32'(mode[k] == 1));
      check($sformatf("u%0d.done", k), gd[k], 32'(mode[k] == 2));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [5:0] pat;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; din = 1'b0;
    for (int k = 0; k < 3; k++) begin mode[k] = 0; cnt[k] = 0; vec[k] = '0; end
    step();
    do_reset();

    // Basic fill of 1,0,1,1,0,1
    pat = 6'b101101;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 5; i >= 0; i--) begin din = pat[i]; step(); end
    check("basic_out", 32'(out0), 32'h2D);
    check("basic_done", 32'(done0), 32'h1);
    step();
    check("basic_idle_done", 32'(done0), 32'h0);

    // Offset range and degenerate width, din all ones
    do_reset();
    din = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    step();
    check("w1_out", 32'(out2), 32'h1);
    check("w1_done", 32'(done2), 32'h1);
    for (int i = 0; i < 3; i++) step();
    check("offset_out", 32'(out1), 32'hF);
    check("offset_done", 32'(done1), 32'h1);
    for (int i = 0; i < 3; i++) step();

    // Abort on the third FILL cycle
    do_reset();
    din = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    abort = 1'b1; step(); abort = 1'b0;
    check("abort_out", 32'(out0), 32'h30);
    check("abort_busy", 32'(busy0), 32'h0);
    step(); step();
    check("abort_nodone", 32'(done0), 32'h0);

    // start held high, then start together with abort in idle
    start = 1'b1;
    for (int i = 0; i < 24; i++) begin din = 1'($urandom); step(); end
    abort = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("start_abort_idle", 32'(busy0), 32'h0);
    start = 1'b0; abort = 1'b0;

    // Reset on the fourth FILL cycle
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin din = 1'b1; step(); end
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("rst_mid_out", 32'(out0), 32'h0);
    check("rst_mid_idx", 32'(idx0), 32'h5);
    check("rst_mid_busy", 32'(busy0), 32'h0);
    check("rst_mid_done", 32'(done0), 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      start = ($urandom_range(0, 2) == 0);
      abort = ($urandom_range(0, 9) == 0);
      din   = 1'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
